// File: rtl/gray_codec_unit_if.sv
// gray_codec_unit_if
//   Stream bundle for gray_codec_unit: an operation channel
//   (in_valid/in_ready with mode, direction and operand) and a result channel
//   (out_valid/out_ready with data and wrap flag), plus the registered Gray
//   view of the internal counter.
//   master : drives operations and the result ready (upstream/downstream side)
//   slave  : the codec itself
interface gray_codec_unit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic             in_dir;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic [WIDTH-1:0] cnt_gray;

  modport master (
    output in_valid, in_mode, in_dir, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_wrap, cnt_gray
  );

  modport slave (
    input  in_valid, in_mode, in_dir, in_data, out_ready,
    output in_ready, out_valid, out_data, out_wrap, cnt_gray
  );
endinterface

// File: rtl/gray_codec_unit.sv
// gray_codec_unit
//   Registered binary/Gray engine behind a valid/ready stream. Each accepted
//   operation produces one result one cycle later:
//     mode 0 B2G  : Gray(in_data)
//     mode 1 G2B  : binary(in_data), prefix XOR from the MSB down
//     mode 2 LOAD : counter <= in_data, result Gray(in_data)
//     mode 3 STEP : counter <= counter +/- 1 (in_dir), result Gray(counter),
//                   out_wrap flags the modulo roll-over
//   Ports
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : gray_codec_unit_if.slave (operation, result and cnt_gray)
module gray_codec_unit #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  gray_codec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_B2G  = 2'd0,
    MODE_G2B  = 2'd1,
    MODE_LOAD = 2'd2,
    MODE_STEP = 2'd3
  } modeT;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] toGray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  logic             outValidReg, outValidNext;
  logic [WIDTH-1:0] outDataReg, outDataNext;
  logic             outWrapReg, outWrapNext;
  logic [WIDTH-1:0] counterReg, counterNext;
  logic [WIDTH-1:0] cntGrayReg, cntGrayNext;

  logic             inReady;
  logic             accept;
  logic [WIDTH-1:0] b2gData;
  logic [WIDTH-1:0] g2bData;

  // A slot opens whenever the held result is empty or leaves this edge.
  assign inReady = !outValidReg || bus.out_ready;
  assign accept  = bus.in_valid && inReady;

  // Per-bit converters on the operand. G2B bit i is the XOR of every operand
  // bit from the MSB down to i, written as a reduction so no bit depends on
  // another bit of the same vector.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : gConv
      if (gi == WIDTH - 1) begin : gMsb
        assign b2gData[gi] = bus.in_data[gi];
        assign g2bData[gi] = bus.in_data[gi];
      end else begin : gLow
        assign b2gData[gi] = bus.in_data[gi+1] ^ bus.in_data[gi];
        assign g2bData[gi] = ^bus.in_data[WIDTH-1:gi];
      end
    end
  endgenerate

  always_comb begin
    outValidNext = outValidReg;
    outDataNext  = outDataReg;
    outWrapNext  = outWrapReg;
    counterNext  = counterReg;
    cntGrayNext  = cntGrayReg;

    if (accept) begin
      outValidNext = 1'b1;
      outWrapNext  = 1'b0;
      case (modeT'(bus.in_mode))
        MODE_B2G: begin
          outDataNext = b2gData;
        end
        MODE_G2B: begin
          outDataNext = g2bData;
        end
        MODE_LOAD: begin
          counterNext = bus.in_data;
          outDataNext = b2gData;
          cntGrayNext = b2gData;
        end
        MODE_STEP: begin
          if (!bus.in_dir) begin
            counterNext = counterReg + ONE;
            outWrapNext = (counterReg == '1);
          end else begin
            counterNext = counterReg - ONE;
            outWrapNext = (counterReg == '0);
          end
          outDataNext = toGray(counterNext);
          cntGrayNext = toGray(counterNext);
        end
      endcase
    end else if (bus.out_ready) begin
      // Result consumed with nothing new behind it; data/wrap keep their
      // last values.
      outValidNext = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidReg <= 1'b0;
      outDataReg  <= '0;
      outWrapReg  <= 1'b0;
      counterReg  <= '0;
      cntGrayReg  <= '0;
    end else begin
      outValidReg <= outValidNext;
      outDataReg  <= outDataNext;
      outWrapReg  <= outWrapNext;
      counterReg  <= counterNext;
      cntGrayReg  <= cntGrayNext;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValidReg;
  assign bus.out_data  = outDataReg;
  assign bus.out_wrap  = outWrapReg;
  assign bus.cnt_gray  = cntGrayReg;

endmodule

// File: tb/tb_gray_codec_unit.sv
// tb_gray_codec_unit
//   Scoreboard bench for gray_codec_unit. Two instances: WIDTH=4 (directed
//   cases, counter behaviour, back-pressure, reset, random traffic) and
//   WIDTH=8 (B2G -> G2B round trip over every value). Drivers push expected
//   results when an operation is accepted; negedge monitors pop and compare
//   whenever a result is consumed.
module tb_gray_codec_unit;

  typedef struct packed {
    logic        wrap;
    logic [31:0] data;
  } expT;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cnt4  = 0;
  bit   randReady = 0;
  expT  q4[$];
  expT  q8[$];

  gray_codec_unit_if #(.WIDTH(4)) bus4 ();
  gray_codec_unit_if #(.WIDTH(8)) bus8 ();

  gray_codec_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  gray_codec_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference Gray code straight from the bit rule.
  function automatic logic [31:0] mB2g(input logic [31:0] d, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (i == w - 1) r[i] = d[i];
      else            r[i] = d[i+1] ^ d[i];
    end
    return r;
  endfunction

  // Reference inverse: search for the binary value whose Gray code matches.
  function automatic logic [31:0] mG2b(input logic [31:0] g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if (mB2g(32'(b), w) == g) return 32'(b);
    end
    return '0;
  endfunction

  task automatic op4(input logic [1:0] mode, input logic dir, input logic [3:0] data,
                     input bit useLit, input logic [3:0] litData, input bit litWrap,
                     output int waited);
    expT         e;
    logic [3:0]  prevCnt;
    bus4.in_valid = 1'b1;
    bus4.in_mode  = mode;
    bus4.in_dir   = dir;
    bus4.in_data  = data;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (bus4.in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout4", 32'(bus4.in_ready), 32'd1);
        bus4.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (randReady) bus4.out_ready = 1'($urandom_range(0, 1));
    end
    prevCnt = bus4.cnt_gray;
    @(posedge clk);
    e.wrap = 1'b0;
    case (mode)
      2'd0: e.data = mB2g(32'(data), 4);
      2'd1: e.data = mG2b(32'(data), 4);
      2'd2: begin
        cnt4   = int'(data);
        e.data = mB2g(32'(cnt4), 4);
      end
      default: begin
        if (!dir) begin
          e.wrap = (cnt4 == 15);
          cnt4   = (cnt4 + 1) % 16;
        end else begin
          e.wrap = (cnt4 == 0);
          cnt4   = (cnt4 + 15) % 16;
        end
        e.data = mB2g(32'(cnt4), 4);
      end
    endcase
    if (useLit) begin
      e.data = 32'(litData);
      e.wrap = litWrap;
    end
    q4.push_back(e);
    #1;
    if (mode == 2'd3) check("cnt_step_onebit", 32'($countones(prevCnt ^ bus4.cnt_gray)), 32'd1);
    bus4.in_valid = 1'b0;
    if (randReady) bus4.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic op8(input logic [1:0] mode, input logic [7:0] data, input logic [7:0] expD);
    expT e;
    int  waited;
    bus8.in_valid = 1'b1;
    bus8.in_mode  = mode;
    bus8.in_dir   = 1'b0;
    bus8.in_data  = data;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (bus8.in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout8", 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    e.wrap = 1'b0;
    e.data = 32'(expD);
    q8.push_back(e);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  // Monitors: compare on every consumed result.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cnt_gray4", 32'(bus4.cnt_gray), mB2g(32'(cnt4), 4));
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          check("unexpected_result4", 32'(bus4.out_valid), 32'd0);
        end else begin
          expT e;
          e = q4.pop_front();
          $display("txn4 data=%h wrap=%b", bus4.out_data, bus4.out_wrap);
          check("out_data4", 32'(bus4.out_data), e.data);
          check("out_wrap4", 32'(bus4.out_wrap), 32'(e.wrap));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_result8", 32'(bus8.out_valid), 32'd0);
      end else begin
        expT e;
        e = q8.pop_front();
        $display("txn8 data=%h wrap=%b", bus8.out_data, bus8.out_wrap);
        check("out_data8", 32'(bus8.out_data), e.data);
        check("out_wrap8", 32'(bus8.out_wrap), 32'(e.wrap));
      end
    end
  end

  logic [3:0] b2gTable [16];
  int         w;

  initial begin
    b2gTable = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_mode = 2'd0; bus4.in_dir = 1'b0; bus4.in_data = '0;
    bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_mode = 2'd0; bus8.in_dir = 1'b0; bus8.in_data = '0;
    bus8.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_out_data", 32'(bus4.out_data), 32'd0);
    check("rst_out_wrap", 32'(bus4.out_wrap), 32'd0);
    check("rst_cnt_gray", 32'(bus4.cnt_gray), 32'd0);
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Down-wrap from reset
    op4(2'd3, 1'b1, 4'd0, 1, 4'b1000, 1'b1, w);
    op4(2'd3, 1'b1, 4'd0, 1, 4'b1001, 1'b0, w);

    // Exhaustive B2G, one per cycle
    for (int i = 0; i < 16; i++) begin
      op4(2'd0, 1'b0, 4'(i), 1, b2gTable[i], 1'b0, w);
      check("b2g_no_stall", 32'(w), 32'd0);
    end

    // G2B
    op4(2'd1, 1'b0, 4'b1110, 1, 4'b1011, 1'b0, w);
    op4(2'd1, 1'b0, 4'b1000, 1, 4'b1111, 1'b0, w);

    // Up-wrap
    op4(2'd2, 1'b0, 4'b1110, 1, 4'b1001, 1'b0, w);
    op4(2'd3, 1'b0, 4'd0, 1, 4'b1000, 1'b0, w);
    op4(2'd3, 1'b0, 4'd0, 1, 4'b0000, 1'b1, w);
    check("upwrap_cnt_gray", 32'(bus4.cnt_gray), 32'd0);

    // Back-pressure
    op4(2'd0, 1'b0, 4'b0101, 1, 4'b0111, 1'b0, w);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_mode   = 2'd3;
    bus4.in_dir    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus4.out_valid), 32'd1);
      check("bp_out_data", 32'(bus4.out_data), 32'b0111);
      check("bp_cnt_gray", 32'(bus4.cnt_gray), 32'b0000);
      @(posedge clk);
      #1;
    end
    bus4.out_ready = 1'b1;
    op4(2'd3, 1'b0, 4'd0, 1, 4'b0001, 1'b0, w);
    check("bp_same_edge_accept", 32'(w), 32'd0);

    // WIDTH=8 round trip
    for (int b = 0; b < 256; b++) begin
      op8(2'd0, 8'(b), 8'(mB2g(32'(b), 8)));
      op8(2'd1, 8'(mB2g(32'(b), 8)), 8'(b));
    end

    // Random traffic with random back-pressure
    randReady = 1;
    repeat (300) begin
      op4(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          0, 4'd0, 1'b0, w);
    end
    randReady = 0;
    bus4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("random_drain4", 32'(q4.size()), 32'd0);

    // Reset mid-stream
    op4(2'd2, 1'b0, 4'b0110, 1, 4'b0101, 1'b0, w);
    bus4.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus4.out_data), 32'd0);
    check("midrst_cnt_gray", 32'(bus4.cnt_gray), 32'd0);
    check("midrst_in_ready", 32'(bus4.in_ready), 32'd1);
    q4.delete();
    cnt4 = 0;
    #2;
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    op4(2'd3, 1'b0, 4'd0, 1, 4'b0001, 1'b0, w);

    repeat (3) @(posedge clk);
    #1;
    check("final_drain4", 32'(q4.size()), 32'd0);
    check("final_drain8", 32'(q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
